// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between pipeline stages of the display chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_sprite.sv
// Two-stage sprite compositor: overlays a SPR_W x SPR_H ROM sprite onto the VGA stream.
// Optional colour keying is enabled by defining DRAW_SPRITE_TRANSPARENT_EN.
module draw_sprite #(
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 16,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input  logic                             clk,
  input  logic                             rst,
  vga_if.in                                vga_in,
  vga_if.out                               vga_out,
  input  logic [10:0]                      xpos,
  input  logic [10:0]                      ypos,
  output logic [$clog2(SPR_W*SPR_H)-1:0]   rom_addr,
  input  logic [11:0]                      rom_data
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int AW = XW + YW;

  logic          vblnk_d_r;
  logic [10:0]   xpos_l_r;
  logic [10:0]   ypos_l_r;

  logic [10:0]   s1_hcount_r;
  logic [10:0]   s1_vcount_r;
  logic          s1_hsync_r;
  logic          s1_vsync_r;
  logic          s1_hblnk_r;
  logic          s1_vblnk_r;
  logic [11:0]   s1_rgb_r;
  logic          s1_hit_r;
  logic [AW-1:0] rom_addr_r;

  logic          vblnk_rise_s;
  logic [11:0]   x_end_s;
  logic [11:0]   y_end_s;
  logic          hit_s;
  logic [XW-1:0] dx_s;
  logic [YW-1:0] dy_s;
  logic          key_s;
  logic [11:0]   rgb_s;

  assign rom_addr = rom_addr_r;

  // Hit test and ROM address; edge sums are 12 bits so a sprite near column/row 2047 cannot wrap to 0.
  always_comb begin
    vblnk_rise_s = vga_in.vblnk & ~vblnk_d_r;
    x_end_s      = {1'b0, xpos_l_r} + 12'(SPR_W);
    y_end_s      = {1'b0, ypos_l_r} + 12'(SPR_H);
    dx_s         = XW'(vga_in.hcount - xpos_l_r);
    dy_s         = YW'(vga_in.vcount - ypos_l_r);
    if ((vga_in.hcount >= xpos_l_r) && ({1'b0, vga_in.hcount} < x_end_s) &&
        (vga_in.vcount >= ypos_l_r) && ({1'b0, vga_in.vcount} < y_end_s) &&
        !vga_in.hblnk && !vga_in.vblnk) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Colour key detection on the ROM pixel.
  always_comb begin
`ifdef DRAW_SPRITE_TRANSPARENT_EN
    if (rom_data == KEY_RGB) begin
      key_s = 1'b1;
    end else begin
      key_s = 1'b0;
    end
`else
    key_s = 1'b0;
`endif
  end

  // Stage-2 colour selection; blanking forces black.
  always_comb begin
    if (s1_hblnk_r || s1_vblnk_r) begin
      rgb_s = 12'h000;
    end else if (s1_hit_r && !key_s) begin
      rgb_s = rom_data;
    end else begin
      rgb_s = s1_rgb_r;
    end
  end

  // Vblank history and frame-boundary position latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d_r <= 1'b0;
      xpos_l_r  <= 11'd0;
      ypos_l_r  <= 11'd0;
    end else begin
      vblnk_d_r <= vga_in.vblnk;
      if (vblnk_rise_s) begin
        xpos_l_r <= xpos;
        ypos_l_r <= ypos;
      end
    end
  end

  // Stage 1: timing, background, hit flag and ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount_r <= 11'd0;
      s1_vcount_r <= 11'd0;
      s1_hsync_r  <= 1'b0;
      s1_vsync_r  <= 1'b0;
      s1_hblnk_r  <= 1'b0;
      s1_vblnk_r  <= 1'b0;
      s1_rgb_r    <= 12'h000;
      s1_hit_r    <= 1'b0;
      rom_addr_r  <= {AW{1'b0}};
    end else begin
      s1_hcount_r <= vga_in.hcount;
      s1_vcount_r <= vga_in.vcount;
      s1_hsync_r  <= vga_in.hsync;
      s1_vsync_r  <= vga_in.vsync;
      s1_hblnk_r  <= vga_in.hblnk;
      s1_vblnk_r  <= vga_in.vblnk;
      s1_rgb_r    <= vga_in.rgb;
      s1_hit_r    <= hit_s;
      rom_addr_r  <= {dy_s, dx_s};
    end
  end

  // Stage 2: registered composited output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'h000;
    end else begin
      vga_out.hcount <= s1_hcount_r;
      vga_out.vcount <= s1_vcount_r;
      vga_out.hsync  <= s1_hsync_r;
      vga_out.vsync  <= s1_vsync_r;
      vga_out.hblnk  <= s1_hblnk_r;
      vga_out.vblnk  <= s1_vblnk_r;
      vga_out.rgb    <= rgb_s;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: drives 1024x768 timing windows and checks every output cycle.
module tb_draw_sprite;

  localparam logic [11:0] KEY = 12'h0F0;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] xpos = 11'd0;
  logic [10:0] ypos = 11'd0;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rom [0:511];

  vga_if vin ();
  vga_if vout ();

  draw_sprite #(.SPR_W(32), .SPR_H(16), .KEY_RGB(KEY)) dut (
    .clk      (clk),
    .rst      (rst),
    .vga_in   (vin),
    .vga_out  (vout),
    .xpos     (xpos),
    .ypos     (ypos),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // ROM answers the registered address within the following cycle
  assign rom_data = rom[rom_addr];

  int          total = 0;
  int          bad = 0;
  int          drawn = 0;
  logic [10:0] mx = 11'd0;
  logic [10:0] my = 11'd0;
  logic        m_vb_prev = 1'b0;
  pix_t        exp_prev = '0;
  pix_t        exp_cur = '0;
  bit          prev_valid = 1'b0;

  function automatic pix_t model(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg);
    pix_t        p;
    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] col;
    logic [8:0]  a;
    p.h   = h;
    p.v   = v;
    p.hs  = (h >= 11'd1048) && (h < 11'd1184);
    p.vs  = (v >= 11'd771) && (v < 11'd777);
    p.hb  = (h >= 11'd1024);
    p.vb  = (v >= 11'd768);
    dx    = {1'b0, h} - {1'b0, mx};
    dy    = {1'b0, v} - {1'b0, my};
    if (p.hb || p.vb) begin
      p.rgb = 12'h000;
    end else if ((h >= mx) && (dx < 12'd32) && (v >= my) && (dy < 12'd16)) begin
      a   = {dy[3:0], dx[4:0]};
      col = rom[a];
`ifdef DRAW_SPRITE_TRANSPARENT_EN
      p.rgb = (col == KEY) ? bg : col;
`else
      p.rgb = col;
`endif
    end else begin
      p.rgb = bg;
    end
    return p;
  endfunction

  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg, input logic r);
    pix_t p;
    p          = model(h, v, bg);
    rst        = r;
    vin.hcount = h;
    vin.vcount = v;
    vin.hsync  = p.hs;
    vin.vsync  = p.vs;
    vin.hblnk  = p.hb;
    vin.vblnk  = p.vb;
    vin.rgb    = bg;
    if (r) begin
      exp_prev  = '0;
      exp_cur   = '0;
      prev_valid = 1'b1;
      mx        = 11'd0;
      my        = 11'd0;
      m_vb_prev = 1'b0;
    end else begin
      exp_cur = p;
      if (p.vb && !m_vb_prev) begin
        mx = xpos;
        my = ypos;
      end
      m_vb_prev = p.vb;
    end
    @(posedge clk);
    #1;
    if (prev_valid) begin
      total++;
      assert ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} ===
              {exp_prev.h, exp_prev.v, exp_prev.hs, exp_prev.vs, exp_prev.hb, exp_prev.vb})
      else begin
        bad++;
        $error("FAIL timing h=%0d v=%0d: observed %0d/%0d/%b%b%b%b expected %0d/%0d/%b%b%b%b",
               exp_prev.h, exp_prev.v, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
               vout.hblnk, vout.vblnk, exp_prev.h, exp_prev.v, exp_prev.hs, exp_prev.vs,
               exp_prev.hb, exp_prev.vb);
      end
      total++;
      assert (vout.rgb === exp_prev.rgb)
      else begin
        bad++;
        $error("FAIL rgb h=%0d v=%0d: observed %h expected %h", exp_prev.h, exp_prev.v,
               vout.rgb, exp_prev.rgb);
      end
      if (vout.rgb[11]) drawn++;
    end
    if (r) begin
      total++;
      assert (rom_addr === 9'd0)
      else begin
        bad++;
        $error("FAIL rst_rom_addr: observed %h expected 000", rom_addr);
      end
    end
    exp_prev   = exp_cur;
    prev_valid = 1'b1;
  endtask

  task automatic flush(input logic [10:0] v);
    step(11'd1100, v, 12'h00F, 1'b0);
    step(11'd1100, v, 12'h00F, 1'b0);
  endtask

  task automatic vrise();
    step(11'd1100, 11'd767, 12'h00F, 1'b0);
    step(11'd0, 11'd770, 12'h00F, 1'b0);
  endtask

  task automatic sweep(input int v0, input int v1, input int h0, input int h1, input logic [11:0] bg);
    drawn = 0;
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        step(11'(h), 11'(v), bg, 1'b0);
      end
    end
    flush(11'(v1));
  endtask

  task automatic check_cnt(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'hF00;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h000;

    // reset state
    repeat (3) step(11'd0, 11'd0, 12'h00F, 1'b1);

    // basic placement at 100,200
    xpos = 11'd100; ypos = 11'd200;
    vrise();
    sweep(198, 217, 95, 136, 12'h00F);
    check_cnt("place_100_200", drawn, 512);

    // timing passthrough across full lines and the vsync region
    sweep(767, 768, 0, 1343, 12'h00F);
    sweep(769, 778, 1040, 1060, 12'h00F);

    // mid-frame position change waits for the next vblank rise
    xpos = 11'd100; ypos = 11'd400;
    vrise();
    for (int h = 0; h < 8; h++) step(11'(h), 11'd400, 12'h00F, 1'b0);
    xpos = 11'd300;
    sweep(400, 415, 95, 136, 12'h00F);
    check_cnt("midframe_old_pos", drawn, 512);
    sweep(400, 415, 295, 336, 12'h00F);
    check_cnt("midframe_new_hidden", drawn, 0);
    vrise();
    sweep(400, 415, 295, 336, 12'h00F);
    check_cnt("nextframe_new_pos", drawn, 512);
    sweep(400, 415, 95, 136, 12'h00F);
    check_cnt("nextframe_old_gone", drawn, 0);

    // right/bottom clipping
    xpos = 11'd1010; ypos = 11'd760;
    vrise();
    sweep(755, 770, 1000, 1040, 12'h00F);
    check_cnt("clip_corner", drawn, 112);
    sweep(0, 3, 0, 30, 12'h00F);
    check_cnt("clip_no_wrap", drawn, 0);

    // sprite edges beyond 11 bits must not wrap to column/row 0
    xpos = 11'd2030; ypos = 11'd2040;
    vrise();
    sweep(0, 8, 0, 30, 12'h00F);
    check_cnt("edge_sum_no_wrap", drawn, 0);

    // vblnk high on the first post-reset cycle is a rising edge
    xpos = 11'd50; ypos = 11'd20;
    step(11'd0, 11'd770, 12'h00F, 1'b1);
    step(11'd0, 11'd770, 12'h00F, 1'b0);
    sweep(18, 37, 45, 86, 12'h00F);
    check_cnt("post_reset_rise", drawn, 512);

    // reset mid-line clears the latched position until the next vblank rise
    xpos = 11'd300; ypos = 11'd400;
    for (int h = 0; h < 10; h++) step(11'(h), 11'd5, 12'h00F, 1'b0);
    for (int h = 10; h < 13; h++) step(11'(h), 11'd5, 12'h00F, 1'b1);
    for (int h = 13; h <= 40; h++) step(11'(h), 11'd5, 12'h00F, 1'b0);
    flush(11'd5);
    sweep(0, 15, 0, 40, 12'h00F);
    check_cnt("reset_pos_zero", drawn, 512);
    vrise();
    sweep(398, 417, 295, 336, 12'h00F);
    check_cnt("reset_then_reload", drawn, 512);

    // colour key on ROM pixel 0
    rom[0] = 12'h0F0;
    xpos = 11'd100; ypos = 11'd200;
    vrise();
    step(11'd99, 11'd200, 12'h123, 1'b0);
    step(11'd100, 11'd200, 12'h123, 1'b0);
    step(11'd101, 11'd200, 12'h123, 1'b0);
    total++;
`ifdef DRAW_SPRITE_TRANSPARENT_EN
    assert (vout.rgb === 12'h123)
    else begin
      bad++;
      $error("FAIL key_pixel0: observed %h expected 123", vout.rgb);
    end
`else
    assert (vout.rgb === 12'h0F0)
    else begin
      bad++;
      $error("FAIL key_pixel0: observed %h expected 0F0", vout.rgb);
    end
`endif
    flush(11'd200);

    // address ordering with a distinct value per ROM word
    for (int i = 0; i < 512; i++) rom[i] = 12'h800 | 12'(i);
    xpos = 11'd517; ypos = 11'd333;
    vrise();
    sweep(330, 350, 510, 553, 12'h00F);
    check_cnt("pattern_rom", drawn, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 SHALL have parameter SPR_W, default 32, sprite width in pixels (power of 2).
REQ-002 SHALL have parameter SPR_H, default 16, sprite height in pixels (power of 2).
REQ-003 SHALL have parameter KEY_RGB, default 12'h0F0, transparent colour key.
REQ-004 SHALL have port clk  input  1  pixel clock, 65 MHz.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vga_in  vga_if.in  bundle  timing plus background rgb from the upstream stage: hcount/vcount 11b, hsync, vsync, hblnk, vblnk, rgb 12b.
REQ-007 SHALL have port vga_out  vga_if.out  bundle  the same signal set, sprite composited over the background.
REQ-008 SHALL have port xpos  input  11  requested sprite left-edge column.
REQ-009 SHALL have port ypos  input  11  requested sprite top-edge row.
REQ-010 SHALL have port rom_addr  output  log2(SPR_W*SPR_H)  sprite ROM address.
REQ-011 SHALL have port rom_data  input  12  ROM pixel, valid exactly one cycle after rom_addr.

Function
REQ-012 SHALL be a 2-stage pipeline; every vga_out field is the vga_in field of 2 cycles earlier, except rgb.
REQ-013 Stage 1 SHALL register all vga_in fields, hit flag and rom_addr = {vcount-ypos_l (low log2 SPR_H bits), hcount-xpos_l (low log2 SPR_W bits)}.
REQ-014 hit SHALL be 1 iff xpos_l <= hcount < xpos_l+SPR_W and ypos_l <= vcount < ypos_l+SPR_H and hblnk=0 and vblnk=0.
REQ-015 Edge sums SHALL be computed 12 bits wide; no wrap-around; columns/rows past the visible area are never drawn.
REQ-016 Stage 2 SHALL output rgb = rom_data when stage-1 hit=1, else stage-1 rgb.
REQ-017 When stage-1 hblnk or vblnk=1, vga_out.rgb SHALL be 12'h000.
REQ-018 xpos_l/ypos_l SHALL load xpos/ypos only on the cycle where vga_in.vblnk is 1 and was 0 the previous cycle; position changes mid-frame SHALL have no visible effect until then.
REQ-019 A position change and a vblnk rising edge in the same cycle SHALL load the new value.
REQ-020 rom_addr SHALL be driven every cycle; its value when hit=0 is don't-care but SHALL be registered.
REQ-021 Edge-detect state SHALL be a registered copy of vga_in.vblnk.

Reset
REQ-022 During rst every vga_out field, rom_addr, stage-1 registers and the vblnk history register SHALL be 0 on the next clock edge.
REQ-023 xpos_l and ypos_l SHALL reset to 0.
REQ-024 Reset asserted mid-frame SHALL discard pipeline contents; after deassertion first valid output SHALL appear 2 cycles later.
REQ-025 A vblnk high at the first post-reset cycle SHALL count as a rising edge (history is 0).

Configuration
REQ-026 Macro DRAW_SPRITE_TRANSPARENT_EN SHALL control colour keying.
REQ-027 With DRAW_SPRITE_TRANSPARENT_EN defined, stage 2 SHALL output background rgb when hit=1 and rom_data==KEY_RGB.
REQ-028 Without it, rom_data SHALL be output on every hit regardless of value.

Verification
REQ-029 Latched position 100,200, ROM all 12'hF00, background 12'h00F: vga_out.rgb=F00 exactly for hcount 100..131, vcount 200..215 (timing-aligned); 00F elsewhere in active area.
REQ-030 Change xpos 100->300 at vcount 400: rest of frame draws at 100; next frame draws at 300 after vblnk rise.
REQ-031 xpos=1010, ypos=760: only columns 1010..1023, rows 760..767 drawn; nothing in blanking; no wrap to column 0 / row 0.
REQ-032 ROM pixel 0 = 12'h0F0, background 12'h123: with DRAW_SPRITE_TRANSPARENT_EN, output at (xpos_l,ypos_l) = 123; without it, 0F0.
REQ-033 Compare vga_out hcount/vcount/hsync/vsync/hblnk/vblnk vs vga_in delayed 2 cycles over a full frame: zero mismatches.
REQ-034 Assert rst for 3 cycles mid-line: all outputs 0 from first reset edge; correct 2-cycle-delayed data resumes 2 cycles after release; xpos_l=0 until next vblnk rise.
